// File: rtl/soundbar_pkg.sv
// Shared definitions for the soundbar level path: widths, decay states,
// amplitude-to-step quantiser and the 16-step thermometer encoder.
`timescale 1ns/1ps
package soundbar_pkg;

    localparam int LEVEL_W   = 5;
    localparam int BAR_STEPS = 16;
    localparam int OLED_W    = 96;
    localparam int OLED_H    = 64;
    localparam int AMP_W     = 11;

    // TRACK: a fresh peak is being held (hold > 0).
    // DECAY: hold expired, level falls one step per window.
    typedef enum logic {
        TRACK,
        DECAY
    } decay_state_e;

    // Round-up quantiser: 0 -> 0, 1..128 -> 1, ..., 1921..2047 -> 16.
    function automatic logic [LEVEL_W-1:0] peak_to_target(
        input logic [AMP_W-1:0] peak
    );
        logic [AMP_W:0]       sum;
        logic [LEVEL_W-1:0]   q;
        sum = {1'b0, peak} + 12'd127;
        q   = LEVEL_W'(sum >> 7);
        return (q > 5'd16) ? 5'd16 : q;
    endfunction

    function automatic logic [BAR_STEPS-1:0] thermo16(
        input logic [LEVEL_W-1:0] level
    );
        logic [BAR_STEPS-1:0] t;
        t = '0;
        for (int i = 0; i < BAR_STEPS; i++) begin
            t[i] = (LEVEL_W'(i) < level);
        end
        return t;
    endfunction

endpackage

// File: rtl/soundbar_peak_window.sv
// Mic amplitude, running peak and sample-count window.
// Ports: clock, reset (async high), sample_valid, mic_in[11:0] in;
//        win_end (comb pulse), target[4:0] (comb, valid at win_end),
//        peak_out[10:0] (peak of last completed window) out.
`timescale 1ns/1ps
module soundbar_peak_window
    import soundbar_pkg::*;
#(
    parameter int WINDOW = 4000,
    parameter int CENTRE = 2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    output logic        win_end,
    output logic [4:0]  target,
    output logic [10:0] peak_out
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam logic [11:0] CENTRE_S = 12'(CENTRE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      peak_run_q, peak_run_d;
    logic [10:0]      peak_out_q, peak_out_d;
    logic [11:0]      diff;
    logic [10:0]      amp;
    logic [10:0]      peak_fin;

    always_comb begin
        if (mic_in >= CENTRE_S) begin
            diff = mic_in - CENTRE_S;
        end else begin
            diff = CENTRE_S - mic_in;
        end
        // Full-scale negative (code 0) is 2048 away; clamp to 11 bits.
        amp = (diff > 12'd2047) ? 11'h7FF : diff[10:0];
    end

    // Peak including the current sample, so the closing sample counts.
    assign peak_fin = (amp > peak_run_q) ? amp : peak_run_q;
    assign win_end  = sample_valid && (cnt_q == LAST);
    assign target   = peak_to_target(peak_fin);
    assign peak_out = peak_out_q;

    always_comb begin
        cnt_d      = cnt_q;
        peak_run_d = peak_run_q;
        peak_out_d = peak_out_q;
        if (sample_valid) begin
            if (win_end) begin
                cnt_d      = '0;
                peak_run_d = '0;
                peak_out_d = peak_fin;
            end else begin
                cnt_d      = cnt_q + CNT_W'(1);
                peak_run_d = peak_fin;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            peak_run_q <= '0;
            peak_out_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            peak_run_q <= peak_run_d;
            peak_out_q <= peak_out_d;
        end
    end

endmodule

// File: rtl/soundbar_level_ctrl.sv
// Peak-hold/decay volume level and frame-synchronous thermometer output.
// Ports: clock, reset (async high), sample_valid, mic_in[11:0],
//        index[12:0], freeze in; level[4:0], tester[15:0],
//        peak_out[10:0], frame_tick out.
`timescale 1ns/1ps
module soundbar_level_ctrl
    import soundbar_pkg::*;
#(
    parameter int WINDOW        = 4000,
    parameter int DECAY_WINDOWS = 2,
    parameter int CENTRE        = 2048,
    parameter int FRAME_PIX     = OLED_W * OLED_H
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    input  logic [12:0] index,
    input  logic        freeze,
    output logic [4:0]  level,
    output logic [15:0] tester,
    output logic [10:0] peak_out,
    output logic        frame_tick
);

    localparam int HOLD_W = $clog2(DECAY_WINDOWS + 2);
    localparam int IDX_W  = $clog2(FRAME_PIX);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(DECAY_WINDOWS);

    logic              win_end;
    logic [4:0]        target;
    logic [4:0]        level_q, level_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    decay_state_e      state_q, state_d;
    logic [15:0]       tester_q, tester_d;
    logic              tick_q, tick_d;
    logic [IDX_W-1:0]  idx_prev_q, idx_prev_d;
    logic              boundary;

    soundbar_peak_window #(
        .WINDOW (WINDOW),
        .CENTRE (CENTRE)
    ) u_peak (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .mic_in       (mic_in),
        .win_end      (win_end),
        .target       (target),
        .peak_out     (peak_out)
    );

    always_comb begin
        level_d = level_q;
        hold_d  = hold_q;
        state_d = state_q;
        if (win_end) begin
            if (target >= level_q) begin
                level_d = target;
                hold_d  = HOLD_INIT;
                state_d = (DECAY_WINDOWS == 0) ? DECAY : TRACK;
            end else begin
                unique case (state_q)
                    TRACK: begin
                        hold_d = hold_q - HOLD_W'(1);
                        if (hold_q == HOLD_W'(1)) begin
                            state_d = DECAY;
                        end
                    end
                    DECAY: begin
                        // target < level here, so one step never undershoots.
                        level_d = level_q - 5'd1;
                    end
                endcase
            end
        end
    end

    // Falling edge of "index nonzero": a level on 0 must not retrigger.
    // Latch uses level_q, so a same-cycle window update shows next frame.
    always_comb begin
        boundary   = (idx_prev_q != '0) && (index == '0);
        tick_d     = boundary && !freeze;
        tester_d   = tick_d ? thermo16(level_q) : tester_q;
        idx_prev_d = index[IDX_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q    <= '0;
            hold_q     <= '0;
            state_q    <= DECAY;
            tester_q   <= '0;
            tick_q     <= 1'b0;
            idx_prev_q <= '0;
        end else begin
            level_q    <= level_d;
            hold_q     <= hold_d;
            state_q    <= state_d;
            tester_q   <= tester_d;
            tick_q     <= tick_d;
            idx_prev_q <= idx_prev_d;
        end
    end

    assign level      = level_q;
    assign tester     = tester_q;
    assign frame_tick = tick_q;

endmodule
